// File: rtl/strip_scan_sequencer_if.sv
// Injector-side bundle between strip_scan_sequencer (master) and comparator_injector (slave):
// half-strip select, counter clear, fire handshake and the muxed error count.
interface strip_scan_sequencer_if #(
  parameter int unsigned HS_BITS = 5
);
  logic [HS_BITS-1:0] active_halfstrip;
  logic               halfstrip_mask_en;
  logic               fire_pulse;
  logic               errcnt_rst;
  logic               pulser_ready;
  logic [15:0]        errcnt;

  modport master (
    output active_halfstrip, halfstrip_mask_en, fire_pulse, errcnt_rst,
    input  pulser_ready, errcnt
  );

  modport slave (
    input  active_halfstrip, halfstrip_mask_en, fire_pulse, errcnt_rst,
    output pulser_ready, errcnt
  );
endinterface

// File: rtl/strip_scan_sequencer.sv
// Steps the injector across a half-strip range: clear counters, settle, fire, compare errcnt to a limit.
// Optional handshake watchdog enabled by defining SCAN_TIMEOUT_EN.
module strip_scan_sequencer #(
  parameter int unsigned HS_BITS        = 5,
  parameter int unsigned SETTLE_BITS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [HS_BITS-1:0]     hs_first,
  input  logic [HS_BITS-1:0]     hs_last,
  input  logic [SETTLE_BITS-1:0] settle_cycles,
  input  logic [15:0]            err_limit,
  strip_scan_sequencer_if.master inj,
  output logic [31:0]            fail_map,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SETTLE, S_FIRE, S_WAIT_BUSY, S_WAIT_DONE, S_EVAL, S_DONE
  } state_t;

  state_t                 state_q;
  logic [HS_BITS-1:0]     hs_q;
  logic [HS_BITS-1:0]     last_q;
  logic [SETTLE_BITS-1:0] settle_q;
  logic [SETTLE_BITS-1:0] settle_cnt_q;
  logic [15:0]            limit_q;
  logic [31:0]            fail_map_q;
  logic                   fire_pulse_q;
  logic                   errcnt_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   range_err_q;

  logic in_wait_c;
  logic wd_hit_c;
  logic strip_end_c;
  logic strip_fail_c;

  assign in_wait_c    = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  // A watchdog expiry ends the strip exactly like EVAL, but always marks it failed.
  assign strip_end_c  = (state_q == S_EVAL) || wd_hit_c;
  assign strip_fail_c = wd_hit_c || ((state_q == S_EVAL) && (inj.errcnt > limit_q));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hs_q         <= '0;
      last_q       <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      limit_q      <= '0;
      fail_map_q   <= '0;
      fire_pulse_q <= 1'b0;
      errcnt_rst_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      fire_pulse_q <= 1'b0;
      errcnt_rst_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              last_q      <= hs_last;
              settle_q    <= settle_cycles;
              limit_q     <= err_limit;
              fail_map_q  <= '0;
              range_err_q <= 1'b0;
              busy_q      <= 1'b1;
              if (hs_first > hs_last) begin
                range_err_q <= 1'b1;
                done_q      <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                hs_q         <= hs_first;
                errcnt_rst_q <= 1'b1;
                state_q      <= S_CLR;
              end
            end
          end
          S_CLR: begin
            settle_cnt_q <= settle_q;
            state_q      <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt_q == '0) begin
              fire_pulse_q <= 1'b1;
              state_q      <= S_FIRE;
            end else begin
              settle_cnt_q <= settle_cnt_q - SETTLE_BITS'(1);
            end
          end
          S_FIRE:      state_q <= S_WAIT_BUSY;
          S_WAIT_BUSY: if (!inj.pulser_ready) state_q <= S_WAIT_DONE;
          S_WAIT_DONE: if (inj.pulser_ready)  state_q <= S_EVAL;
          S_EVAL:      state_q <= S_EVAL;
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default:     state_q <= S_IDLE;
        endcase

        // Last-index test precedes the increment so hs_last at the top index cannot wrap.
        if (strip_end_c) begin
          if (strip_fail_c) fail_map_q[hs_q] <= 1'b1;
          if (hs_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            hs_q         <= hs_q + HS_BITS'(1);
            errcnt_rst_q <= 1'b1;
            state_q      <= S_CLR;
          end
        end
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] wd_q;
  logic               timeout_q;

  assign wd_hit_c = in_wait_c && (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1));

  // Watchdog spans WAIT_BUSY plus WAIT_DONE of one strip; timeout is sticky until the next start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start && !abort) timeout_q <= 1'b0;
      if (wd_hit_c && !abort)                     timeout_q <= 1'b1;
      if (state_q == S_FIRE)  wd_q <= '0;
      else if (in_wait_c)     wd_q <= wd_q + WD_BITS'(1);
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_hit_c           = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign inj.active_halfstrip  = hs_q;
  assign inj.halfstrip_mask_en = busy_q;
  assign inj.fire_pulse        = fire_pulse_q;
  assign inj.errcnt_rst        = errcnt_rst_q;
  assign fail_map              = fail_map_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign range_err             = range_err_q;

endmodule

// File: tb/tb_strip_scan_sequencer.sv
// Directed self-checking bench for strip_scan_sequencer with a behavioural injector model.
module tb_strip_scan_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  hs_first = '0;
  logic [4:0]  hs_last = '0;
  logic [7:0]  settle_cycles = '0;
  logic [15:0] err_limit = '0;
  logic [31:0] fail_map;
  logic        busy, done, range_err, timeout;

  int checks = 0;
  int errors = 0;

  strip_scan_sequencer_if #(.HS_BITS(5)) bus ();

  strip_scan_sequencer #(
    .HS_BITS(5), .SETTLE_BITS(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .hs_first(hs_first), .hs_last(hs_last), .settle_cycles(settle_cycles),
    .err_limit(err_limit), .inj(bus), .fail_map(fail_map), .busy(busy),
    .done(done), .range_err(range_err), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Injector model: after a fire, busy (ready low) for busy_len+1 cycles; stuck holds ready high.
  logic [15:0] err_tab [32];
  int          busy_len = 2;
  logic        stuck = 1'b0;
  int          inj_cnt;

  assign bus.errcnt = err_tab[bus.active_halfstrip];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pulser_ready <= 1'b1;
      inj_cnt          <= 0;
    end else if (stuck) begin
      bus.pulser_ready <= 1'b1;
    end else if (bus.fire_pulse) begin
      bus.pulser_ready <= 1'b0;
      inj_cnt          <= busy_len;
    end else if (!bus.pulser_ready) begin
      if (inj_cnt == 0) bus.pulser_ready <= 1'b1;
      else              inj_cnt <= inj_cnt - 1;
    end
  end

  // Event log written only here; tests read it when the DUT is quiet.
  int         cyc = 0;
  int         n_done = 0;
  logic [4:0] fire_idx[$];
  int         fire_cyc[$];
  int         rst_cyc[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.fire_pulse === 1'b1) begin
      fire_idx.push_back(bus.active_halfstrip);
      fire_cyc.push_back(cyc);
    end
    if (bus.errcnt_rst === 1'b1) rst_cyc.push_back(cyc);
    if (done === 1'b1) n_done = n_done + 1;
  end

  task automatic clear_tab();
    for (int i = 0; i < 32; i++) err_tab[i] = 16'd0;
  endtask

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l,
                             input logic [7:0] s, input logic [15:0] lim);
    @(negedge clock);
    hs_first = f; hs_last = l; settle_cycles = s; err_limit = lim; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (fail_map !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || range_err !== 1'b0 ||
        timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: fail_map=%h busy=%b done=%b range_err=%b timeout=%b, expected all 0",
               fail_map, busy, done, range_err, timeout);
    end
    checks++;
    if (bus.active_halfstrip !== 5'd0 || bus.fire_pulse !== 1'b0 || bus.errcnt_rst !== 1'b0 ||
        bus.halfstrip_mask_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_inj: hs=%0d fire=%b rst=%b mask=%b, expected all 0",
               bus.active_halfstrip, bus.fire_pulse, bus.errcnt_rst, bus.halfstrip_mask_en);
    end
  endtask

  task automatic test_basic_scan();
    int f0, r0, d0;
    clear_tab();
    err_tab[4] = 16'd7;
    busy_len = 3;
    f0 = fire_idx.size(); r0 = rst_cyc.size(); d0 = n_done;
    pulse_start(5'd3, 5'd5, 8'd2, 16'd0);
    checks++;
    if (busy !== 1'b1 || bus.errcnt_rst !== 1'b1 || bus.active_halfstrip !== 5'd3 ||
        bus.halfstrip_mask_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_cycle: busy=%b rst=%b hs=%0d mask=%b, expected 1 1 3 1",
               busy, bus.errcnt_rst, bus.active_halfstrip, bus.halfstrip_mask_en);
    end
    wait_idle(1000, "basic");
    checks++;
    if (fail_map !== 32'h0000_0010) begin
      errors++;
      $display("FAIL basic_fail_map: got %h expected 00000010", fail_map);
    end
    checks++;
    if (fire_idx.size() - f0 != 3 || rst_cyc.size() - r0 != 3) begin
      errors++;
      $display("FAIL basic_pulse_counts: fires=%0d clears=%0d expected 3 3",
               fire_idx.size() - f0, rst_cyc.size() - r0);
    end
    checks++;
    if (n_done - d0 != 1 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done pulses=%0d range_err=%b expected 1 0", n_done - d0, range_err);
    end
    // CLR (1) + SETTLE (settle+1 = 3) separates the clear from the fire.
    checks++;
    if (fire_cyc[f0] - rst_cyc[r0] != 4) begin
      errors++;
      $display("FAIL basic_settle_timing: clear-to-fire=%0d expected 4", fire_cyc[f0] - rst_cyc[r0]);
    end
  endtask

  task automatic test_top_wrap();
    int f0, d0;
    clear_tab();
    err_tab[31] = 16'd5;
    busy_len = 1;
    f0 = fire_idx.size(); d0 = n_done;
    pulse_start(5'd30, 5'd31, 8'd0, 16'd4);
    wait_idle(1000, "wrap");
    checks++;
    if (fire_idx.size() - f0 != 2) begin
      errors++;
      $display("FAIL wrap_fire_count: got %0d expected 2", fire_idx.size() - f0);
    end else begin
      checks++;
      if (fire_idx[f0] !== 5'd30 || fire_idx[f0+1] !== 5'd31) begin
        errors++;
        $display("FAIL wrap_indices: got %0d,%0d expected 30,31", fire_idx[f0], fire_idx[f0+1]);
      end
    end
    checks++;
    if (fail_map !== 32'h8000_0000 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL wrap_result: fail_map=%h done pulses=%0d expected 80000000 1", fail_map, n_done - d0);
    end
  endtask

  task automatic test_range_err();
    int f0, d0;
    f0 = fire_idx.size(); d0 = n_done;
    pulse_start(5'd9, 5'd4, 8'd2, 16'd0);
    checks++;
    if (range_err !== 1'b1 || done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL range_first_cycle: range_err=%b done=%b busy=%b expected 1 1 1", range_err, done, busy);
    end
    wait_idle(50, "range");
    checks++;
    if (fire_idx.size() != f0 || n_done - d0 != 1 || range_err !== 1'b1 || fail_map !== 32'h0) begin
      errors++;
      $display("FAIL range_result: fires=%0d done=%0d range_err=%b fail_map=%h expected 0 1 1 00000000",
               fire_idx.size() - f0, n_done - d0, range_err, fail_map);
    end
  endtask

  task automatic test_abort();
    int f0, d0, n;
    clear_tab();
    err_tab[1] = 16'd9;
    busy_len = 2;
    f0 = fire_idx.size(); d0 = n_done;
    pulse_start(5'd0, 5'd5, 8'd4, 16'd3);
    n = 0;
    while (!(bus.errcnt_rst === 1'b1 && bus.active_halfstrip === 5'd2) && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL abort_reach_strip2: hs=%0d, strip 2 clear never seen", bus.active_halfstrip);
    end
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.halfstrip_mask_en !== 1'b0 || fail_map !== 32'h2 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b mask=%b fail_map=%h range_err=%b expected 0 0 00000002 0",
               busy, bus.halfstrip_mask_en, fail_map, range_err);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (n_done != d0 || fire_idx.size() - f0 != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: done=%0d fires=%0d busy=%b expected 0 2 0",
               n_done - d0, fire_idx.size() - f0, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int f0, d0;
    clear_tab();
    err_tab[11] = 16'd1;
    busy_len = 2;
    f0 = fire_idx.size(); d0 = n_done;
    pulse_start(5'd10, 5'd12, 8'd1, 16'd0);
    repeat (5) @(negedge clock);
    hs_first = 5'd0; hs_last = 5'd20; err_limit = 16'd100; settle_cycles = 8'd50;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(1000, "busy_start");
    checks++;
    if (fail_map !== 32'h0000_0800 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL busy_start_result: fail_map=%h done=%0d expected 00000800 1", fail_map, n_done - d0);
    end
    checks++;
    if (fire_idx.size() - f0 != 3) begin
      errors++;
      $display("FAIL busy_start_fires: got %0d expected 3", fire_idx.size() - f0);
    end else begin
      checks++;
      if (fire_idx[f0] !== 5'd10 || fire_idx[f0+2] !== 5'd12) begin
        errors++;
        $display("FAIL busy_start_range: first=%0d last=%0d expected 10 12", fire_idx[f0], fire_idx[f0+2]);
      end
    end
  endtask

  task automatic test_timeout();
    int n, d0;
    clear_tab();
    stuck = 1'b1;
    d0 = n_done;
    pulse_start(5'd6, 5'd7, 8'd0, 16'd0);
`ifdef SCAN_TIMEOUT_EN
    n = 0;
    while (bus.fire_pulse !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != 101) begin
      errors++;
      $display("FAIL timeout_latency: timeout after %0d cycles from fire, expected 101", n);
    end
    checks++;
    if (bus.active_halfstrip !== 5'd7 || bus.errcnt_rst !== 1'b1 || fail_map !== 32'h40) begin
      errors++;
      $display("FAIL timeout_next_strip: hs=%0d rst=%b fail_map=%h expected 7 1 00000040",
               bus.active_halfstrip, bus.errcnt_rst, fail_map);
    end
    wait_idle(500, "timeout");
    checks++;
    if (fail_map !== 32'hC0 || timeout !== 1'b1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL timeout_result: fail_map=%h timeout=%b done=%0d expected 000000c0 1 1",
               fail_map, timeout, n_done - d0);
    end
`else
    n = 0;
    repeat (150) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0 || fail_map !== 32'h0 || n_done != d0) begin
      errors++;
      $display("FAIL stall_wait: busy=%b timeout=%b fail_map=%h done=%0d expected 1 0 00000000 0",
               busy, timeout, fail_map, n_done - d0);
    end
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL stall_abort: busy=%b timeout=%b expected 0 0", busy, timeout);
    end
`endif
    stuck = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_scan();
    int n;
    clear_tab();
    err_tab[0] = 16'd5;
    busy_len = 2;
    pulse_start(5'd0, 5'd3, 8'd1, 16'd0);
    n = 0;
    while (!(bus.errcnt_rst === 1'b1 && bus.active_halfstrip === 5'd1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (fail_map !== 32'h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: fail_map=%h busy=%b expected 00000001 1", fail_map, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (fail_map !== 32'h0 || busy !== 1'b0 || bus.active_halfstrip !== 5'd0 ||
        bus.fire_pulse !== 1'b0 || bus.errcnt_rst !== 1'b0 || bus.halfstrip_mask_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_values: fail_map=%h busy=%b hs=%0d fire=%b rst=%b mask=%b expected all 0",
               fail_map, busy, bus.active_halfstrip, bus.fire_pulse, bus.errcnt_rst, bus.halfstrip_mask_en);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    clear_tab();
    test_reset();
    test_basic_scan();
    test_top_wrap();
    test_range_err();
    test_abort();
    test_start_while_busy();
    test_timeout();
    test_reset_mid_scan();
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
